// File: rtl/mtl1_pkg.sv
// rtl/mtl1_pkg.sv - shared types and defaults for the 6809 bus glue blocks
package mtl1_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_READ    = 3'd2,
        S_WRITE   = 3'd3,
        S_RECOVER = 3'd4
    } sram_state_t;

    localparam int SRAM_OE_DELAY = 1;
    localparam int SRAM_WE_DELAY = 2;
    localparam int SRAM_TIMEOUT  = 200;

endpackage

// File: rtl/sync_rise_det.sv
// rtl/sync_rise_det.sv - N-stage synchronizer with rising-edge pulse
module sync_rise_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;
    logic              level;

    // Shift the asynchronous input through the chain; prev holds the last synced level
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    // Chain and edge-history registers, cleared on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;

endmodule

// File: rtl/e_sram_cycle.sv
// rtl/e_sram_cycle.sv - turns decoded 6809 E cycles into SRAM strobes on the fast clock
module e_sram_cycle
    import mtl1_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int OE_DELAY    = SRAM_OE_DELAY,
    parameter int WE_DELAY    = SRAM_WE_DELAY,
    parameter int TIMEOUT     = SRAM_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_e_clk,
    input  logic i_sram_window,
    input  logic i_sel,
    input  logic i_rw,
    input  logic i_wr_protect,
    output logic o_sram_ce_n,
    output logic o_sram_oe_n,
    output logic o_sram_we_n,
    output logic o_bus_drive,
    output logic o_busy,
    output logic o_wr_blocked,
    output logic o_timeout,
    output logic o_overrun
);

    localparam logic [7:0] OE_CNT  = 8'(OE_DELAY);
    localparam logic [7:0] WE_CNT  = 8'(WE_DELAY);
    localparam logic [7:0] TMO_CNT = 8'(TIMEOUT);

    logic        e_rise;

    sram_state_t state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  cnt_inc;
    logic        rw_q, rw_d;
    logic        wp_q, wp_d;

    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        bus_drive_q, bus_drive_d;
    logic        busy_q, busy_d;
    logic        wr_blocked_q, wr_blocked_d;
    logic        timeout_q, timeout_d;
    logic        overrun_q, overrun_d;

    sync_rise_det #(
        .STAGES (SYNC_STAGES)
    ) u_e_rise (
        .clk   (i_clk),
        .reset (i_reset),
        .d     (i_e_clk),
        .rise  (e_rise)
    );

    // Next-state: window loss and timeout pre-empt the strobe-delay compares
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rw_d         = rw_q;
        wp_d         = wp_q;
        wr_blocked_d = 1'b0;
        timeout_d    = 1'b0;
        cnt_inc      = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

        case (state_q)
            S_IDLE: begin
                if (e_rise && i_sel) begin
                    rw_d    = i_rw;
                    wp_d    = i_wr_protect;
                    cnt_d   = 8'd0;
                    // A zero read delay lets OE# fall together with CE#
                    state_d = (i_rw && OE_DELAY == 0) ? S_READ : S_ADDR;
                end
            end
            S_ADDR, S_READ, S_WRITE: begin
                cnt_d = cnt_inc;
                if (cnt_q == TMO_CNT) begin
                    state_d   = S_RECOVER;
                    timeout_d = 1'b1;
                end else if (!i_sram_window) begin
                    state_d = S_RECOVER;
                end else if (state_q == S_ADDR) begin
                    // Compare against the count this cycle ends on, so OE# lands OE_DELAY after CE#
                    if (rw_q && cnt_inc == OE_CNT) begin
                        state_d = S_READ;
                    end else if (!rw_q && cnt_inc == WE_CNT) begin
                        state_d      = S_WRITE;
                        wr_blocked_d = wp_q;
                    end
                end
            end
            S_RECOVER: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output decode from the current state; registered so pins never see input glitches
    always_comb begin
        ce_n_d      = (state_q == S_IDLE);
        oe_n_d      = (state_q != S_READ);
        we_n_d      = !((state_q == S_WRITE) && !wp_q);
        bus_drive_d = (state_q == S_READ) || ((state_q == S_RECOVER) && bus_drive_q);
        busy_d      = (state_d != S_IDLE);
        overrun_d   = e_rise && (state_q != S_IDLE);
    end

    // State, counter and output registers; reset drops every strobe immediately
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            rw_q         <= 1'b0;
            wp_q         <= 1'b0;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            bus_drive_q  <= 1'b0;
            busy_q       <= 1'b0;
            wr_blocked_q <= 1'b0;
            timeout_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rw_q         <= rw_d;
            wp_q         <= wp_d;
            ce_n_q       <= ce_n_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            bus_drive_q  <= bus_drive_d;
            busy_q       <= busy_d;
            wr_blocked_q <= wr_blocked_d;
            timeout_q    <= timeout_d;
            overrun_q    <= overrun_d;
        end
    end

    assign o_sram_ce_n  = ce_n_q;
    assign o_sram_oe_n  = oe_n_q;
    assign o_sram_we_n  = we_n_q;
    assign o_bus_drive  = bus_drive_q;
    assign o_busy       = busy_q;
    assign o_wr_blocked = wr_blocked_q;
    assign o_timeout    = timeout_q;
    assign o_overrun    = overrun_q;

endmodule
